// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared widths, bus timeout and memory FSM state encodings.
package mem_access_stage_pkg;
    localparam int DSIZE   = 16;
    localparam int ISIZE   = 16;
    localparam int RADDR   = 4;
    localparam int TIMEOUT = 255;
    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;
endpackage

// File: rtl/mem_bus_fsm.sv
// mem_bus_fsm: req/ack data-bus sequencer with wait counter, timeout and sticky bus_err.
module mem_bus_fsm
    import mem_access_stage_pkg::*;
#(
    parameter int DW      = DSIZE,
    parameter int TMO     = TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_op,
    input  logic          we,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          acked,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          bus_err
);
    mem_state_e state, next;
    logic [7:0] cnt;
    logic       busy, tmo, done;

    always_comb begin
        busy  = state == MEM_WAIT;
        acked = busy & mem_ack;
        tmo   = busy & ~mem_ack & (cnt == 8'(TMO));
        done  = acked | tmo;
        // gated by rst so stall reads 0 while the core is held in reset
        stall = rst & (busy ? ~done : mem_op);
        next  = busy ? (done ? MEM_IDLE : MEM_WAIT) : (mem_op ? MEM_WAIT : MEM_IDLE);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= MEM_IDLE;
        else      state <= next;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            bus_err   <= 1'b0;
        end else if (!busy && mem_op) begin
            mem_req   <= 1'b1;
            mem_we    <= we;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            cnt       <= '0;
        end else if (busy) begin
            if (done) mem_req <= 1'b0;
            if (tmo) bus_err <= 1'b1;
            cnt <= cnt + 8'd1;
        end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage; drives the data bus and the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DW  = DSIZE,
    parameter int IW  = ISIZE,
    parameter int RW  = RADDR,
    parameter int TMO = TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] w_addr_in,
    input  logic [DW-1:0] w_data_in,
    input  logic [DW-1:0] Rdata2_in,
    input  logic          memWrite_in,
    input  logic          memRead_in,
    input  logic          memToReg_in,
    input  logic          wen_in,
    input  logic          jal_in,
    input  logic [IW-1:0] PC_in,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [RW-1:0] w_addr_out,
    output logic [DW-1:0] w_data_out,
    output logic          wen_out,
    output logic          bus_err
);
    logic          acked;
    logic [DW-1:0] wb;

    mem_bus_fsm #(.DW(DW), .TMO(TMO)) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .mem_op   (memRead_in | memWrite_in),
        .we       (memWrite_in),
        .addr     (w_data_in),
        .wdata    (Rdata2_in),
        .mem_ack  (mem_ack),
        .stall    (stall),
        .acked    (acked),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .bus_err  (bus_err)
    );

    // a timed-out load returns 0 because acked stays low
    always_comb
        wb = jal_in ? DW'(PC_in) + DW'(1) : memToReg_in ? (acked ? mem_rdata : '0) : w_data_in;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            w_addr_out <= '0;
            w_data_out <= '0;
            wen_out    <= 1'b0;
        end else begin
            w_addr_out <= w_addr_in;
            w_data_out <= wb;
            wen_out    <= wen_in & ~stall;
        end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks against a transaction-level model.
module tb_mem_access_stage;
    logic        clk = 0, rst = 0;
    logic [3:0]  w_addr_in = 0, w_addr_out;
    logic [15:0] w_data_in = 0, Rdata2_in = 0, PC_in = 0, mem_rdata = 0;
    logic        memWrite_in = 0, memRead_in = 0, memToReg_in = 0, wen_in = 0, jal_in = 0, mem_ack = 0;
    logic        stall, mem_req, mem_we, wen_out, bus_err;
    logic [15:0] mem_addr, mem_wdata, w_data_out;
    int total = 0, bad = 0;
    bit err_m = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .w_addr_in(w_addr_in), .w_data_in(w_data_in), .Rdata2_in(Rdata2_in),
        .memWrite_in(memWrite_in), .memRead_in(memRead_in), .memToReg_in(memToReg_in), .wen_in(wen_in),
        .jal_in(jal_in), .PC_in(PC_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .w_addr_out(w_addr_out), .w_data_out(w_data_out), .wen_out(wen_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    // One instruction; lat = WAIT cycles before ack, anything above 255 never acks.
    task automatic op(input string tag, input logic [3:0] wa, input logic [15:0] wd, input logic [15:0] rd2,
                      input bit mr, input bit mw, input bit m2r, input bit wen, input bit jal,
                      input logic [15:0] pc, input int lat, input logic [15:0] rdata);
        bit mop, fin;
        int k, stalls;
        logic [15:0] exp;
        mop = mr | mw;
        exp = jal ? pc + 16'd1 : m2r ? ((mop && lat <= 255) ? rdata : 16'h0) : wd;
        mem_ack = 0;
        w_addr_in = wa; w_data_in = wd; Rdata2_in = rd2; memRead_in = mr; memWrite_in = mw;
        memToReg_in = m2r; wen_in = wen; jal_in = jal; PC_in = pc;
        #1 chk({tag, ".stall_idle"}, stall, mop);
        @(posedge clk); #1;
        if (mop) begin
            chk({tag, ".req"}, mem_req, 1);
            chk({tag, ".we"}, mem_we, mw);
            chk({tag, ".addr"}, mem_addr, wd);
            if (mw) chk({tag, ".wdata"}, mem_wdata, rd2);
            chk({tag, ".bubble"}, wen_out, 0);
            stalls = 1; k = 0; fin = 0;
            while (!fin && k < 300) begin
                mem_ack = (k == lat);
                mem_rdata = (k == lat) ? rdata : 16'($urandom);
                fin = (k == lat) || (k == 255);
                #1 if (k < 3 || fin) chk({tag, ".stall_wait"}, stall, !fin);
                if (stall) stalls++;
                @(posedge clk); #1;
                if (!fin && k < 3) chk({tag, ".req_hold"}, {mem_req, wen_out}, 2'b10);
                k++;
            end
            mem_ack = 0;
            chk({tag, ".finished"}, fin, 1);
            chk({tag, ".req_drop"}, mem_req, 0);
            chk({tag, ".addr_hold"}, mem_addr, wd);
            chk({tag, ".stalls"}, stalls, (lat <= 255) ? lat + 1 : 256);
            if (lat > 255) err_m = 1;
        end
        chk({tag, ".wdata_out"}, w_data_out, exp);
        chk({tag, ".wen_out"}, wen_out, wen);
        chk({tag, ".waddr_out"}, w_addr_out, wa);
        chk({tag, ".bus_err"}, bus_err, err_m);
    endtask

    initial begin
        #3;
        chk("rst.req", mem_req, 0);
        chk("rst.stall", stall, 0);
        chk("rst.wen", wen_out, 0);
        chk("rst.wdata", w_data_out, 0);
        chk("rst.err", bus_err, 0);
        @(negedge clk); @(negedge clk) rst = 1;
        @(posedge clk); #1;
        op("alu", 3, 16'h1234, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        op("load", 5, 16'h0040, 0, 1, 0, 1, 1, 0, 0, 3, 16'hBEEF);
        op("store", 2, 16'h0010, 16'h00AA, 1, 1, 0, 0, 0, 0, 0, 0);
        op("jal", 15, 0, 0, 0, 0, 0, 1, 1, 16'h0020, 0, 0);
        op("jal_wrap", 15, 0, 0, 0, 0, 0, 1, 1, 16'hFFFF, 0, 0);
        op("ack_at_tmo", 6, 16'h0300, 0, 1, 0, 1, 1, 0, 0, 255, 16'h5A5A);
        op("timeout", 7, 16'h0200, 0, 1, 0, 1, 1, 0, 0, 1000, 16'hDEAD);
        op("after_tmo", 1, 16'h4321, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            op($sformatf("rnd%0d", i), 4'($urandom), 16'($urandom), 16'($urandom),
               kind == 1, kind == 2, kind == 1, 1'($urandom), kind == 3, 16'($urandom),
               $urandom_range(0, 4), 16'($urandom));
        end
        w_data_in = 16'h0080; memRead_in = 1; memWrite_in = 0; memToReg_in = 1; wen_in = 1; jal_in = 0;
        @(posedge clk); @(posedge clk); @(posedge clk); #3;
        rst = 0;
        #1;
        chk("arst.req", mem_req, 0);
        chk("arst.stall", stall, 0);
        chk("arst.wen", wen_out, 0);
        chk("arst.err", bus_err, 0);
        err_m = 0;
        memRead_in = 0; memToReg_in = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        op("post_rst", 9, 16'h0BAD, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
